// File: rtl/apb3_pkg.sv
// Shared types and widths for the APB3 register slave.
package apb3_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Transfer request captured at the end of SETUP.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb3_wait_ctr.sv
// Wait-state down-counter: load, decrement, zero flag.
module apb3_wait_ctr
  import apb3_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero_c
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes priority over decrement; decrement saturates at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/apb3_reg_slave.sv
// APB3 register slave: NUM_REGS-1 read/write byte registers plus a read-only
// transfer counter at the last index, WAIT_CYCLES wait states per transfer.
// Optional: define APB_SLVERR_EN to flag unmapped accesses and counter writes
// on PSLVERR; otherwise PSLVERR is tied low.
module apb3_reg_slave
  import apb3_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              RESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned REG_N   = NUM_REGS - 1;
  localparam int unsigned CTR_IDX = NUM_REGS - 1;

  apb_state_e        r_state, w_state_nxt;
  apb_req_t          r_req, w_req;
  logic [DATA_W-1:0] r_regs [REG_N];
  logic [DATA_W-1:0] r_xfer_cnt;
  logic [DATA_W-1:0] r_prdata;
  logic              r_pready;
  logic              r_pslverr;

  logic [CNT_W-1:0]  w_wait_cnt;
  logic              w_wait_zero;
  logic              w_load;
  logic              w_dec;
  logic              w_pready_nxt;
  logic              w_is_ctr;
  logic              w_err;
  logic [DATA_W-1:0] w_rd_val;

  apb3_wait_ctr u_wait_ctr (
    .i_clk      (PCLK),
    .i_rst      (RESET),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (CNT_W'(WAIT_CYCLES)),
    .o_cnt      (w_wait_cnt),
    .o_zero_c   (w_wait_zero)
  );

  // Live bus values while in SETUP (not yet latched), latched values after.
  always_comb begin
    w_req = r_req;
    if (r_state == SETUP) begin
      w_req.write = PWRITE;
      w_req.addr  = PADDR;
      w_req.wdata = PWDATA;
    end
  end

  // Read mux and error decode for the effective request.
  always_comb begin
    w_is_ctr = (32'(w_req.addr) == CTR_IDX);
    w_rd_val = '0;
    for (int i = 0; i < int'(REG_N); i++) begin
      if (w_req.addr == ADDR_W'(i)) w_rd_val = r_regs[i];
    end
    if (w_is_ctr) w_rd_val = r_xfer_cnt;
`ifdef APB_SLVERR_EN
    w_err = (32'(w_req.addr) >= NUM_REGS) | (w_req.write & w_is_ctr);
`else
    w_err = 1'b0;
`endif
  end

  // Next state, wait-counter control and the PREADY of the coming cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_pready_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) w_state_nxt = SETUP;
      end
      SETUP: begin
        w_state_nxt  = ACCESS;
        w_load       = 1'b1;
        w_pready_nxt = (WAIT_CYCLES == 0);
      end
      ACCESS: begin
        if (w_wait_zero) begin
          w_state_nxt = (PSEL && !PENABLE) ? SETUP : IDLE;
        end else if (!PSEL) begin
          w_state_nxt = IDLE;
        end else begin
          w_dec        = 1'b1;
          w_pready_nxt = (w_wait_cnt == CNT_W'(1));
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Capture the request at the end of SETUP; bus changes in ACCESS are ignored.
  always_ff @(posedge PCLK) begin
    if (RESET)                 r_req <= '0;
    else if (r_state == SETUP) r_req <= w_req;
  end

  // Registered response; read data and error appear only in the ready cycle.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_pready  <= w_pready_nxt;
      r_prdata  <= (w_pready_nxt && !w_req.write) ? w_rd_val : '0;
      r_pslverr <= w_pready_nxt & w_err;
    end
  end

  // Commit writes and count transfers at the end of the ready cycle.
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(REG_N); i++) r_regs[i] <= '0;
      r_xfer_cnt <= '0;
    end else if (r_pready) begin
      r_xfer_cnt <= r_xfer_cnt + DATA_W'(1);
      if (r_req.write) begin
        for (int i = 0; i < int'(REG_N); i++) begin
          if (r_req.addr == ADDR_W'(i)) r_regs[i] <= r_req.wdata;
        end
      end
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule

// File: doc/apb3_reg_slave.md
APB3_REG_SLAVE -- requirements
Module: apb3_reg_slave

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 8, giving the register count; index NUM_REGS-1 is the read-only transfer counter.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted per transfer (0..15).
REQ-003 The block SHALL have port PCLK, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit, the synchronous active-high reset.
REQ-005 The block SHALL have port PSEL, input, 1 bit, the slave select.
REQ-006 The block SHALL have port PENABLE, input, 1 bit, the access phase strobe.
REQ-007 The block SHALL have port PWRITE, input, 1 bit: 1 is write, 0 is read.
REQ-008 The block SHALL have port PADDR, input, 8 bits, the register index.
REQ-009 The block SHALL have port PWDATA, input, 8 bits, the write data.
REQ-010 The block SHALL have port PRDATA, output, 8 bits, the read data.
REQ-011 The block SHALL have port PREADY, output, 1 bit, the transfer-complete signal.
REQ-012 The block SHALL have port PSLVERR, output, 1 bit, the error response, valid only while PREADY=1.

Function
REQ-013 The state machine SHALL have three states: IDLE, SETUP and ACCESS.
REQ-014 IDLE SHALL go to SETUP when PSEL=1 and PENABLE=0.
REQ-015 SETUP SHALL go to ACCESS unconditionally and SHALL latch PADDR, PWRITE, PWDATA and load the wait counter with WAIT_CYCLES.
REQ-016 In ACCESS with a nonzero counter, the block SHALL hold PREADY=0 and decrement the counter; with a zero counter it SHALL assert PREADY=1 for exactly one cycle, so ACCESS lasts WAIT_CYCLES+1 cycles.
REQ-017 On the PREADY=1 cycle, the next state SHALL be SETUP if PSEL=1 and PENABLE=0, otherwise IDLE, giving back-to-back transfers with no idle gap.
REQ-018 A write to index 0..NUM_REGS-2 SHALL commit PWDATA at the end of the PREADY=1 cycle and not earlier.
REQ-019 On a read, PRDATA SHALL show the addressed register during the PREADY=1 cycle and SHALL be 0x00 in every other cycle.
REQ-020 A read from an unmapped index (PADDR >= NUM_REGS) SHALL return 0x00.
REQ-021 A write to an unmapped index or to the counter index SHALL have no effect on any register.
REQ-022 The transfer counter SHALL increment by 1 on every completed transfer (read or write, mapped or not) and SHALL wrap from 255 to 0.
REQ-023 If PSEL drops in ACCESS before PREADY, the transfer SHALL abort to IDLE with no write, no counter increment and PREADY=0.
REQ-024 PSEL=1 with PENABLE=1 while in IDLE SHALL be ignored: the state stays IDLE and PREADY stays 0.
REQ-025 Changes to PADDR, PWRITE or PWDATA during ACCESS SHALL be ignored in favour of the values latched in SETUP.

Reset
REQ-026 With RESET=1 at a PCLK edge, the block SHALL go to IDLE, clear all registers and the transfer counter to 0x00, and drive PRDATA=0x00, PREADY=0 and PSLVERR=0.
REQ-027 RESET SHALL take priority over any transfer in progress; an interrupted write SHALL NOT commit.

Configuration
REQ-028 With APB_SLVERR_EN defined, PSLVERR SHALL be 1 during the PREADY=1 cycle of any access to an unmapped index and of any write to the counter index.
REQ-029 Without APB_SLVERR_EN, the PSLVERR port SHALL remain present and tied to 0, and error cases SHALL complete silently as described in REQ-020 and REQ-021.

Structure
REQ-030 Package apb3_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS), ADDR_W=8, DATA_W=8 and the wait-counter width.
REQ-031 The wait-state counter SHALL be a sub-module, apb3_wait_ctr, with load, decrement and zero-flag functions.

Verification
REQ-032 Write 0x5A to index 3 with WAIT_CYCLES=2 -> PREADY=0 for 2 ACCESS cycles, then PREADY=1; reg3 reads back 0x5A; counter reads 2.
REQ-033 Back-to-back transfers: write 0x11 to index 0, then immediately SETUP a read of index 0 -> PRDATA=0x11 on its PREADY cycle, with no IDLE cycle between the transfers.
REQ-034 Read index 9 with APB_SLVERR_EN -> PRDATA=0x00 and PSLVERR=1. Write 0xFF to index 7 -> PSLVERR=1 and the counter value is unchanged apart from its increment. Without the macro -> PSLVERR=0 in both cases.
REQ-035 Drop PSEL in the first ACCESS cycle of a write of 0xAA to index 2 -> reg2 stays 0x00 and the counter is unchanged.
REQ-036 Perform 256 reads of index 1 -> the counter wraps to 0x00 and the next read of index 7 returns 0x00 (that read's own increment takes effect after it completes).
REQ-037 Assert RESET during a write's wait states, then repeat all scenarios with WAIT_CYCLES=0 -> the interrupted write does not commit, all outputs are 0, and with WAIT_CYCLES=0 PREADY=1 in the first ACCESS cycle.
